// File: rtl/shared_fu_issue_arbiter_pkg.sv
// Shared-FU issue arbiter package.
// Holds the core-configuration type that supplies the transaction-ID width,
// its default value, the arbiter FSM state type and a small pointer helper.
package shared_fu_issue_arbiter_pkg;

   // Minimal core configuration: only the field this block consumes.
   typedef struct packed {
      int unsigned TRANS_ID_BITS;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{TRANS_ID_BITS: 32'd3};

   // IDLE: free to grant. WAIT: one operation outstanding in the FU.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_e;

   // Cyclic increment of an index in the range [0, n-1].
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/shared_fu_rr_pick.sv
// Combinational cyclic first-one finder.
// Ports:
//   req   - request vector, one bit per requester
//   start - index at which the cyclic search begins (inclusive)
//   grant - one-hot position of the first set request at or after start
//   index - binary index of that position
//   any   - at least one request is set
module shared_fu_rr_pick #(
   parameter int NR_REQ = 2,
   parameter int IDX_W  = $clog2(NR_REQ)
) (
   input  logic [NR_REQ-1:0] req,
   input  logic [IDX_W-1:0]  start,
   output logic [NR_REQ-1:0] grant,
   output logic [IDX_W-1:0]  index,
   output logic              any
);

   always_comb begin
      int pos;
      pos   = 0;
      grant = '0;
      index = '0;
      any   = 1'b0;
      for (int i = 0; i < NR_REQ; i++) begin
         pos = (int'(start) + i) % NR_REQ;
         if (!any && req[IDX_W'(pos)]) begin
            any                = 1'b1;
            grant[IDX_W'(pos)] = 1'b1;
            index              = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/shared_fu_issue_arbiter.sv
// Round-robin issue arbiter for a single shared, non-pipelined functional unit.
// One operation is granted at a time; the unit stays busy until the writeback
// carrying the granted transaction ID arrives. Denied-request cycles are
// counted (saturating) for the performance counters.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   flush_i                  - drop any pending operation, no grant this cycle
//   req_valid_i/req_trans_id_i - per-port request and scoreboard ID
//   req_ack_o, fu_sel_o      - one-hot grant / operand-mux select
//   fu_valid_o, fu_trans_id_o- operation handed to the FU and its ID
//   fu_ready_i               - FU can accept an operation
//   fu_result_valid_i/_trans_id_i - FU writeback
//   busy_o                   - an operation is outstanding
//   stall_cnt_o              - saturating denied-request cycle count
module shared_fu_issue_arbiter
   import shared_fu_issue_arbiter_pkg::*;
#(
   parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
   parameter int        NR_REQ  = 2,
   parameter int        CNT_W   = 16
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         flush_i,
   input  logic [NR_REQ-1:0]                            req_valid_i,
   input  logic [NR_REQ-1:0][CVA6Cfg.TRANS_ID_BITS-1:0] req_trans_id_i,
   output logic [NR_REQ-1:0]                            req_ack_o,
   output logic                                         fu_valid_o,
   output logic [NR_REQ-1:0]                            fu_sel_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0]             fu_trans_id_o,
   input  logic                                         fu_ready_i,
   input  logic                                         fu_result_valid_i,
   input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]             fu_result_trans_id_i,
   output logic                                         busy_o,
   output logic [CNT_W-1:0]                             stall_cnt_o
);

   localparam int TID_W = CVA6Cfg.TRANS_ID_BITS;
   localparam int IDX_W = $clog2(NR_REQ);

   arb_state_e       state_q, state_d;
   logic [TID_W-1:0] pend_id_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic [NR_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic              grant_en;
   logic              stall_inc;

   shared_fu_rr_pick #(
      .NR_REQ (NR_REQ),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req   (req_valid_i),
      .start (rr_ptr_q),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   // Next state and grant decision. Grants are also suppressed while reset is
   // asserted so that every output reads zero during reset.
   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst_ni && !flush_i && fu_ready_i && pick_any) begin
               grant_en = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (fu_result_valid_i && (fu_result_trans_id_i == pend_id_q)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flush beats everything, including a matching writeback.
      if (flush_i) begin
         state_d = IDLE;
      end
   end

   assign req_ack_o     = grant_en ? pick_grant : '0;
   assign fu_sel_o      = req_ack_o;
   assign fu_valid_o    = grant_en;
   assign fu_trans_id_o = grant_en ? req_trans_id_i[pick_idx] : pend_id_q;
   assign busy_o        = (state_q == WAIT);
   assign stall_cnt_o   = stall_cnt_q;

   // Any request left unserved this cycle (flush, WAIT or FU not ready).
   assign stall_inc = (|req_valid_i) && !grant_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pend_id_q   <= '0;
         rr_ptr_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_en) begin
            pend_id_q <= req_trans_id_i[pick_idx];
            rr_ptr_q  <= IDX_W'(wrap_inc(int'(pick_idx), NR_REQ));
         end
         if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_shared_fu_issue_arbiter.sv
// Directed testbench for shared_fu_issue_arbiter (NR_REQ=2, 3-bit IDs).
// A second instance with a 2-bit stall counter shares all inputs and is used
// for the saturation check. Inputs change 1 time unit after the rising edge;
// outputs are sampled 1 time unit later, well away from the edge.
module tb_shared_fu_issue_arbiter;

   logic            clk;
   logic            rst_ni;
   logic            flush;
   logic [1:0]      req_valid;
   logic [1:0][2:0] req_tid;
   logic            fu_ready;
   logic            wb_valid;
   logic [2:0]      wb_tid;

   logic [1:0]  ack;
   logic        fu_valid;
   logic [1:0]  sel;
   logic [2:0]  tid;
   logic        busy;
   logic [15:0] stall;

   logic [1:0]  ack2;
   logic        fu_valid2;
   logic [1:0]  sel2;
   logic [2:0]  tid2;
   logic        busy2;
   logic [1:0]  stall2;

   int errors = 0;
   int checks = 0;

   shared_fu_issue_arbiter #(.NR_REQ(2), .CNT_W(16)) dut (
      .clk_i                (clk),
      .rst_ni               (rst_ni),
      .flush_i              (flush),
      .req_valid_i          (req_valid),
      .req_trans_id_i       (req_tid),
      .req_ack_o            (ack),
      .fu_valid_o           (fu_valid),
      .fu_sel_o             (sel),
      .fu_trans_id_o        (tid),
      .fu_ready_i           (fu_ready),
      .fu_result_valid_i    (wb_valid),
      .fu_result_trans_id_i (wb_tid),
      .busy_o               (busy),
      .stall_cnt_o          (stall)
   );

   shared_fu_issue_arbiter #(.NR_REQ(2), .CNT_W(2)) dut_sat (
      .clk_i                (clk),
      .rst_ni               (rst_ni),
      .flush_i              (flush),
      .req_valid_i          (req_valid),
      .req_trans_id_i       (req_tid),
      .req_ack_o            (ack2),
      .fu_valid_o           (fu_valid2),
      .fu_sel_o             (sel2),
      .fu_trans_id_o        (tid2),
      .fu_ready_i           (fu_ready),
      .fu_result_valid_i    (wb_valid),
      .fu_result_trans_id_i (wb_tid),
      .busy_o               (busy2),
      .stall_cnt_o          (stall2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      req_valid = 2'b00;
      req_tid   = '0;
      fu_ready  = 1'b1;
      wb_valid  = 1'b0;
      wb_tid    = 3'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      #3;
      checks++;
      if ({ack, fu_valid, sel, tid, busy} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs ack=%b valid=%b sel=%b tid=%0d busy=%b want all 0", ack, fu_valid, sel, tid, busy);
      end
      checks++;
      if (stall !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall got=%0d want=0", stall);
      end
      repeat (2) @(posedge clk);
      #3 rst_ni = 1'b1;
      tick();
      $display("reset: outputs idle");
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 2'b01; req_tid[0] = 3'd3;
      #1;
      checks++;
      if (ack !== 2'b01 || sel !== 2'b01 || fu_valid !== 1'b1 || tid !== 3'd3) begin
         errors++;
         $display("FAIL single_grant ack=%b sel=%b valid=%b tid=%0d want 01/01/1/3", ack, sel, fu_valid, tid);
      end
      tick();
      req_valid = 2'b00;
      #1;
      checks++;
      if (busy !== 1'b1 || ack !== 2'b00 || tid !== 3'd3) begin
         errors++;
         $display("FAIL single_wait busy=%b ack=%b tid=%0d want 1/00/3", busy, ack, tid);
      end
      tick();
      wb_valid = 1'b1; wb_tid = 3'd3;
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_at_wb got=%b want=1", busy);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || stall !== 16'd0) begin
         errors++;
         $display("FAIL single_done busy=%b stall=%0d want 0/0", busy, stall);
      end
      $display("single: grant id 3, writeback releases");
   endtask

   task automatic test_contention();
      logic [1:0] exp_ack [3];
      logic [2:0] exp_tid [3];
      exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
      exp_tid[0] = 3'd4;  exp_tid[1] = 3'd5;  exp_tid[2] = 3'd4;
      do_reset();
      req_valid = 2'b11; req_tid[0] = 3'd4; req_tid[1] = 3'd5;
      for (int r = 0; r < 3; r++) begin
         wb_valid = 1'b0;
         #1;
         checks++;
         if (ack !== exp_ack[r] || tid !== exp_tid[r]) begin
            errors++;
            $display("FAIL contention_grant%0d ack=%b tid=%0d want %b/%0d", r, ack, tid, exp_ack[r], exp_tid[r]);
         end
         if (r == 2) break;
         tick();
         #1;
         checks++;
         if (ack !== 2'b00) begin
            errors++;
            $display("FAIL contention_wait%0d ack=%b want=00", r, ack);
         end
         tick();
         wb_valid = 1'b1; wb_tid = exp_tid[r];
         tick();
      end
      // Four denied cycles: two WAIT cycles per completed grant.
      checks++;
      if (stall !== 16'd4) begin
         errors++;
         $display("FAIL contention_stall got=%0d want=4", stall);
      end
      tick();
      idle_inputs();
      $display("contention: grants 01,10,01, stall=4");
   endtask

   task automatic test_wrong_id();
      do_reset();
      req_valid = 2'b01; req_tid[0] = 3'd4;
      tick();
      req_valid = 2'b00; wb_valid = 1'b1; wb_tid = 3'd6;
      tick();
      req_valid = 2'b01; wb_tid = 3'd4;
      #1;
      checks++;
      if (busy !== 1'b1 || ack !== 2'b00) begin
         errors++;
         $display("FAIL wrong_id_ignored busy=%b ack=%b want 1/00", busy, ack);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || ack !== 2'b01 || stall !== 16'd1) begin
         errors++;
         $display("FAIL wrong_id_release busy=%b ack=%b stall=%0d want 0/01/1", busy, ack, stall);
      end
      tick();
      idle_inputs();
      $display("wrong_id: id 6 ignored, id 4 releases");
   endtask

   task automatic test_flush();
      do_reset();
      req_valid = 2'b01; req_tid[0] = 3'd2;
      tick();
      req_valid = 2'b00; flush = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || ack !== 2'b00) begin
         errors++;
         $display("FAIL flush_in_wait busy=%b ack=%b want 1/00", busy, ack);
      end
      tick();
      flush = 1'b0; wb_valid = 1'b1; wb_tid = 3'd2;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_to_idle busy=%b want=0", busy);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_old_wb busy=%b want=0", busy);
      end
      flush = 1'b1; req_valid = 2'b01; req_tid[0] = 3'd1;
      #1;
      checks++;
      if (ack !== 2'b00 || fu_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_grant ack=%b valid=%b want 00/0", ack, fu_valid);
      end
      tick();
      flush = 1'b0; req_valid = 2'b11; req_tid[1] = 3'd7;
      #1;
      checks++;
      if (stall !== 16'd1) begin
         errors++;
         $display("FAIL flush_stall got=%0d want=1", stall);
      end
      // Pointer moved to 1 on the earlier grant and the flushes left it alone.
      checks++;
      if (ack !== 2'b10 || tid !== 3'd7) begin
         errors++;
         $display("FAIL flush_rr_kept ack=%b tid=%0d want 10/7", ack, tid);
      end
      tick();
      idle_inputs();
      $display("flush: wait dropped, idle flush denied");
   endtask

   task automatic test_not_ready();
      do_reset();
      fu_ready = 1'b0; req_valid = 2'b10; req_tid[1] = 3'd5;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (ack !== 2'b00) begin
            errors++;
            $display("FAIL not_ready_ack%0d got=%b want=00", c, ack);
         end
         tick();
      end
      checks++;
      if (stall !== 16'd3 || stall2 !== 2'd3) begin
         errors++;
         $display("FAIL not_ready_stall got=%0d/%0d want=3/3", stall, stall2);
      end
      repeat (2) tick();
      checks++;
      if (stall !== 16'd5 || stall2 !== 2'd3) begin
         errors++;
         $display("FAIL saturation got=%0d/%0d want=5/3", stall, stall2);
      end
      idle_inputs();
      $display("not_ready: stall=3, 2-bit counter saturates at 3");
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      req_valid = 2'b11; req_tid[0] = 3'd5; req_tid[1] = 3'd6;
      tick();
      #1;
      checks++;
      if (busy !== 1'b1 || tid !== 3'd5 || ack !== 2'b00) begin
         errors++;
         $display("FAIL pre_reset busy=%b tid=%0d ack=%b want 1/5/00", busy, tid, ack);
      end
      tick();
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({ack, fu_valid, sel, tid, busy} !== 9'd0 || stall !== 16'd0) begin
         errors++;
         $display("FAIL async_reset ack=%b valid=%b sel=%b tid=%0d busy=%b stall=%0d want all 0", ack, fu_valid, sel, tid, busy, stall);
      end
      @(posedge clk);
      #3 rst_ni = 1'b1;
      #1;
      checks++;
      if (ack !== 2'b01 || tid !== 3'd5) begin
         errors++;
         $display("FAIL post_reset_grant ack=%b tid=%0d want 01/5", ack, tid);
      end
      tick();
      idle_inputs();
      $display("reset_mid_wait: cleared, first grant to requester 0");
   endtask

   initial begin
      idle_inputs();
      rst_ni = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_wrong_id();
      test_flush();
      test_not_ready();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shared_fu_issue_arbiter.md
# shared_fu_issue_arbiter

Arbitrates between the issue ports of the issue stage for a single shared, non-pipelined functional unit (e.g. divider or CSR unit) that cannot accept a second operation until it writes back. Sits between issue-read-operands and the EX-stage FU: grants one requester per operation round-robin, holds the FU busy until the matching transaction ID writes back, and counts arbitration stall cycles for the performance counters.

## Interface
Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; supplies TRANS_ID_BITS.
- NR_REQ, 2, number of requesting issue ports (≥2).
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  flush of unissued/in-flight work.
- req_valid_i  in  NR_REQ  request for the shared FU, one per issue port.
- req_trans_id_i  in  NR_REQ×TRANS_ID_BITS  scoreboard transaction ID per requester.
- req_ack_o  out  NR_REQ  one-hot grant; requester's operation is issued this cycle.
- fu_valid_o  out  1  operation handed to the FU.
- fu_sel_o  out  NR_REQ  one-hot operand-mux select for the FU (equals req_ack_o).
- fu_trans_id_o  out  TRANS_ID_BITS  transaction ID of the issued operation.
- fu_ready_i  in  1  FU can accept an operation.
- fu_result_valid_i  in  1  FU writeback valid.
- fu_result_trans_id_i  in  TRANS_ID_BITS  writeback transaction ID.
- busy_o  out  1  an operation is outstanding.
- stall_cnt_o  out  CNT_W  saturating count of denied-request cycles.

## Operation
- States: IDLE, WAIT. Reset → IDLE.
- IDLE: if flush_i=0, fu_ready_i=1 and any req_valid_i, pick first valid requester at or after rr_ptr (cyclic); assert req_ack_o[g], fu_sel_o[g], fu_valid_o, fu_trans_id_o=req_trans_id_i[g] combinationally; register ID into pend_id; rr_ptr ← (g+1) mod NR_REQ; → WAIT.
- WAIT: no grants; busy_o=1. If fu_result_valid_i and fu_result_trans_id_i==pend_id → IDLE. Non-matching writebacks ignored.
- flush_i=1 in any state: no grant that cycle; → IDLE next cycle; pending result dropped (later matching writeback ignored in IDLE); rr_ptr unchanged.
- stall_cnt_o increments when any req_valid_i=1 and no req_ack_o asserted (includes flush cycles, WAIT, fu_ready_i=0); saturates at 2^CNT_W−1; cleared only by reset.
- fu_trans_id_o: selected ID when granting, else pend_id (0 after reset).

## Timing
- Grant latency: 0 cycles (same-cycle ack in IDLE).
- Writeback in WAIT at cycle t → earliest next grant at t+1; minimum issue-to-issue spacing 2 cycles.
- Writeback in IDLE: ignored, no state change.
- Simultaneous flush_i and matching writeback: flush wins, → IDLE (same result).
- Reset mid-WAIT: all state cleared immediately; outputs at reset: req_ack_o=0, fu_valid_o=0, fu_sel_o=0, fu_trans_id_o=0, busy_o=0, stall_cnt_o=0; rr_ptr=0, state IDLE.
- rr_ptr wraps NR_REQ−1 → 0.

## Structure
- State enum (IDLE/WAIT) in ariane_pkg alongside other issue-stage typedefs; rr_ptr width $clog2(NR_REQ).
- One sub-module: shared_fu_rr_pick — combinational cyclic first-one finder (req vector, start pointer → one-hot grant, index, any).

## Test plan
- Single request: NR_REQ=2, req_valid_i=01, ID=3, fu_ready_i=1 → cycle 0 req_ack_o=01, fu_trans_id_o=3; busy_o=1 until writeback ID=3, IDLE next cycle.
- Contention: req_valid_i=11 held, IDs 4/5, writeback 2 cycles after each grant → grants alternate 01,10,01; stall_cnt_o counts all non-grant cycles.
- Wrong-ID writeback: in WAIT with pend_id=4, writeback ID=6 → stays WAIT, no ack; writeback ID=4 → IDLE.
- Flush: flush_i in WAIT → IDLE next cycle, busy_o=0; subsequent writeback of old ID ignored; flush with request in IDLE → no ack, stall_cnt_o+1.
- fu_ready_i=0 with req_valid_i=10 for 3 cycles → no ack, stall_cnt_o=3; saturation with CNT_W=2 holds at 3.
- Async reset asserted mid-WAIT → all outputs 0 immediately, rr_ptr=0; first grant after reset goes to requester 0 when both request.
